// File: rtl/pea_pkg.sv
// pea_pkg: shared PEA encodings, status-word field offsets and helpers
package pea_pkg;

    typedef enum logic [2:0] {
        GET_COMMAND = 3'b000,
        STP         = 3'b001,
        EVP         = 3'b010,
        EVB         = 3'b011,
        OUTPUT      = 3'b100,
        RST         = 3'b101
    } mode_t;

    typedef enum logic [1:0] {
        TAG_SH = 2'b00,
        TAG_SL = 2'b01,
        TAG_RH = 2'b10,
        TAG_RL = 2'b11
    } tag_t;

    localparam int WS_DEF        = 16;
    localparam int STAT_ERR_BIT  = WS_DEF + 3;
    localparam int STAT_MODE_LSB = WS_DEF;
    localparam int STAT_CNT_MSB  = WS_DEF - 1;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) <= v) r = i;
        return r;
    endfunction

endpackage

// File: rtl/pea_result_reader_if.sv
// pea_result_reader_if: FIFO read ports plus tagged host half-word stream
interface pea_result_reader_if #(
    parameter int WS = 16,
    parameter int PW = pea_pkg::log2(1024) + 1
);
    logic [PW-1:0]   status_population;
    logic            status_rd_en;
    logic [2*WS-1:0] status_data;
    logic [PW-1:0]   result_population;
    logic            result_rd_en;
    logic [2*WS-1:0] result_data;
    logic [WS-1:0]   out_data;
    logic [1:0]      out_tag;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     frames_done;

    modport master (
        input  status_population, status_data, result_population, result_data, out_ready,
        output status_rd_en, result_rd_en, out_data, out_tag, out_last, out_valid, frames_done
    );

    modport slave (
        output status_population, status_data, result_population, result_data, out_ready,
        input  status_rd_en, result_rd_en, out_data, out_tag, out_last, out_valid, frames_done
    );
endinterface

// File: rtl/pea_result_reader.sv
// pea_result_reader: drains PEA status/result FIFOs into a tagged half-word host stream
module pea_result_reader
    import pea_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input logic clk,
    input logic rst,
    pea_result_reader_if.master bus
);
    localparam int PW = log2(buffer_size) + 1;

    typedef enum logic [3:0] {
        IDLE, RD_S, CAP_S, TX_SH, TX_SL, WAIT_R, RD_R, CAP_R, TX_RH, TX_RL
    } state_t;

    state_t                 state, state_nx;
    logic [2*word_size-1:0] hold;
    logic [word_size-1:0]   remaining;
    logic [15:0]            frames_done;
    logic                   tx, hs, last;

    assign tx   = state inside {TX_SH, TX_SL, TX_RH, TX_RL};
    assign hs   = tx && bus.out_ready;
    assign last = remaining == '0;
    assign bus.frames_done = frames_done;

    // state register; reset abandons any frame in progress
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    // next state: one FIFO entry in flight, pops only when nothing is pending
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.status_population != PW'(0) ? RD_S : IDLE;
            RD_S:    state_nx = CAP_S;
            CAP_S:   state_nx = TX_SH;
            TX_SH:   state_nx = hs ? TX_SL : TX_SH;
            TX_SL:   state_nx = hs ? (last ? IDLE : WAIT_R) : TX_SL;
            WAIT_R:  state_nx = bus.result_population != PW'(0) ? RD_R : WAIT_R;
            RD_R:    state_nx = CAP_R;
            CAP_R:   state_nx = TX_RH;
            TX_RH:   state_nx = hs ? TX_RL : TX_RH;
            TX_RL:   state_nx = hs ? (last ? IDLE : WAIT_R) : TX_RL;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from registered state and hold only
    always_comb begin
        bus.status_rd_en = state == RD_S;
        bus.result_rd_en = state == RD_R;
        bus.out_valid    = tx;
        bus.out_tag      = state == TX_SL ? TAG_SL : state == TX_RH ? TAG_RH :
                           state == TX_RL ? TAG_RL : TAG_SH;
        bus.out_data     = state inside {TX_SH, TX_RH} ? hold[2*word_size-1:word_size] :
                           state inside {TX_SL, TX_RL} ? hold[word_size-1:0] : '0;
        bus.out_last     = state inside {TX_SL, TX_RL} && last;
    end

    // hold register, remaining result count and completed-frame counter
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hold        <= '0;
            remaining   <= '0;
            frames_done <= '0;
        end else begin
            if (state == CAP_S) begin
                hold      <= bus.status_data;
                remaining <= bus.status_data[word_size-1:0];
            end
            if (state == CAP_R) begin
                hold      <= bus.result_data;
                remaining <= last ? remaining : remaining - 1'b1;
            end
            if (hs && bus.out_last) frames_done <= frames_done + 1'b1;
        end

endmodule

// File: tb/tb_pea_result_reader.sv
// tb_pea_result_reader: scoreboard bench with FIFO models for the result reader
module tb_pea_result_reader;
    import pea_pkg::*;

    localparam int WS = 16;
    localparam int PW = log2(1024) + 1;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  t;
        logic        l;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pea_result_reader_if #(.WS(WS), .PW(PW)) bus ();

    pea_result_reader #(.word_size(WS), .buffer_size(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    item_t       exp_q[$];
    logic [31:0] sq[$];
    logic [31:0] rq[$];
    int          errors  = 0;
    int          checks  = 0;
    int          st_pops = 0;
    int          rs_pops = 0;
    logic        st_req  = 1'b0;
    logic        rs_req  = 1'b0;
    item_t       got, want;
    int          st_base, rs_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_pair(input logic [31:0] w, input logic res, input logic last);
        exp_q.push_back({w[31:16], res, 1'b0, 1'b0});
        exp_q.push_back({w[15:0], res, 1'b1, last});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_left(input int k, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != k && n < 2000) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic park(input logic [1:0] t, input string tag);
        int n;
        n = 0;
        while (!(bus.out_valid && bus.out_tag == t) && n < 200) begin
            bus.out_ready = bus.out_valid;
            step();
            n++;
        end
        bus.out_ready = 1'b0;
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    // read strobes registered mid-cycle so the FIFO model never races the DUT edge
    always @(negedge clk) begin
        st_req <= bus.status_rd_en;
        rs_req <= bus.result_rd_en;
    end

    // FIFO models: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (st_req && sq.size() > 0) begin
            bus.status_data <= sq.pop_front();
            st_pops++;
        end
        if (rs_req && rq.size() > 0) begin
            bus.result_data <= rq.pop_front();
            rs_pops++;
        end
        bus.status_population <= PW'(sq.size());
        bus.result_population <= PW'(rq.size());
    end

    // scoreboard: every accepted half-word is matched against the next expected one
    always @(negedge clk)
        if (rst && bus.out_valid && bus.out_ready) begin
            chk("sb_extra", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {bus.out_data, bus.out_tag, bus.out_last};
                chk("sb_item", 32'(got), 32'(want));
            end
        end

    initial begin
        bus.out_ready = 1'b0;
        rst = 1'b0;
        step(2);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_srd", 32'(bus.status_rd_en), 32'd0);
        chk("rst_rrd", 32'(bus.result_rd_en), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_frames", 32'(bus.frames_done), 32'd0);
        rst = 1'b1;
        step(3);
        chk("idle_no_pop", 32'(st_pops + rs_pops), 32'd0);

        bus.out_ready = 1'b1;
        sq.push_back(32'h0001_0000);
        exp_pair(32'h0001_0000, 1'b0, 1'b1);
        drain("zero_done");
        chk("zero_frames", 32'(bus.frames_done), 32'd1);
        chk("zero_spops", 32'(st_pops), 32'd1);
        chk("zero_rpops", 32'(rs_pops), 32'd0);

        bus.out_ready = 1'b0;
        sq.push_back(32'h0002_0002);
        rq.push_back(32'h1234_5678);
        rq.push_back(32'h9ABC_DEF0);
        exp_pair(32'h0002_0002, 1'b0, 1'b0);
        exp_pair(32'h1234_5678, 1'b1, 1'b0);
        exp_pair(32'h9ABC_DEF0, 1'b1, 1'b1);
        park(2'b10, "bp_park");
        repeat (7) begin
            step();
            chk("bp_data", 32'(bus.out_data), 32'h1234);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
        end
        chk("bp_rpops", 32'(rs_pops), 32'd1);
        bus.out_ready = 1'b1;
        drain("two_done");
        chk("two_frames", 32'(bus.frames_done), 32'd2);
        chk("two_spops", 32'(st_pops), 32'd2);
        chk("two_rpops", 32'(rs_pops), 32'd2);

        sq.push_back(32'h0003_0003);
        rq.push_back(32'h1111_2222);
        exp_pair(32'h0003_0003, 1'b0, 1'b0);
        exp_pair(32'h1111_2222, 1'b1, 1'b0);
        exp_pair(32'hAAAA_BBBB, 1'b1, 1'b0);
        exp_pair(32'hCCCC_DDDD, 1'b1, 1'b1);
        wait_left(4, "starve_reach");
        repeat (20) begin
            step();
            chk("starve_valid", 32'(bus.out_valid), 32'd0);
        end
        chk("starve_rpops", 32'(rs_pops), 32'd3);
        rq.push_back(32'hAAAA_BBBB);
        rq.push_back(32'hCCCC_DDDD);
        drain("starve_done");
        chk("starve_frames", 32'(bus.frames_done), 32'd3);

        sq.push_back(32'h0001_0001);
        rq.push_back(32'h5555_6666);
        exp_pair(32'h0001_0001, 1'b0, 1'b0);
        exp_pair(32'h5555_6666, 1'b1, 1'b1);
        park(2'b10, "rst_park");
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_frames", 32'(bus.frames_done), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        exp_q.delete();
        sq.delete();
        rq.delete();
        step(2);
        rst = 1'b1;
        st_base = st_pops;
        rs_base = rs_pops;
        step(5);
        chk("post_rst_pops", 32'((st_pops - st_base) + (rs_pops - rs_base)), 32'd0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b1;
        sq.push_back(32'h0003_0001);
        sq.push_back(32'h0005_0000);
        sq.push_back(32'h0001_0001);
        rq.push_back(32'h0101_0202);
        rq.push_back(32'h0303_0404);
        exp_pair(32'h0003_0001, 1'b0, 1'b0);
        exp_pair(32'h0101_0202, 1'b1, 1'b1);
        exp_pair(32'h0005_0000, 1'b0, 1'b1);
        exp_pair(32'h0001_0001, 1'b0, 1'b0);
        exp_pair(32'h0303_0404, 1'b1, 1'b1);
        drain("b2b_done");
        chk("b2b_frames", 32'(bus.frames_done), 32'd3);
        chk("b2b_spops", 32'(st_pops - st_base), 32'd3);
        chk("b2b_rpops", 32'(rs_pops - rs_base), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pea_result_reader.md
Name: pea_result_reader

Overview:
- Host-side drain engine for the PEA output FIFOs: the reading end of the result and status FIFOs that the PEA core writes.
- For each status entry it pops the 2*word_size status word, then pops the number of result words that status announces.
- Each popped word is serialized as two word_size half-words, high half first, onto a valid/ready host stream with frame tags.
- Sits between fifo_out_status/fifo_out_result and the host link.

Parameters:
word_size, 16, host half-word width; FIFO entries are 2*word_size
buffer_size, 1024, FIFO depth; PW = log2(buffer_size)+1 is the population width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
status_population  in  PW  entries currently held in status FIFO
status_rd_en  out  1  pop strobe to status FIFO
status_data  in  2*word_size  status FIFO read data, valid the cycle after status_rd_en
result_population  in  PW  entries currently held in result FIFO
result_rd_en  out  1  pop strobe to result FIFO
result_data  in  2*word_size  result FIFO read data, valid the cycle after result_rd_en
out_data  out  word_size  host half-word
out_tag  out  2  00 status-high, 01 status-low, 10 result-high, 11 result-low
out_last  out  1  final half-word of the current frame
out_valid  out  1  out_data/out_tag/out_last are valid
out_ready  in  1  host accepts the half-word when out_valid && out_ready
frames_done  out  16  count of completed frames, wraps at 2^16

Behaviour:
- Status word format: [2*ws-1:ws+4] reserved (transmitted unchanged); [ws+3] error flag; [ws+2:ws] mode echo (STP=001, EVP=010, EVB=011, RST=101); [ws-1:0] result count N that follows.
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; internal count and holding register 0; frames_done=0. Reset mid-frame abandons the frame. No partial half-word is emitted after rst deasserts.
- FSM states:
  - IDLE: if status_population>0, go to RD_S.
  - RD_S: status_rd_en=1 for exactly one cycle; go to CAP_S.
  - CAP_S: latch status_data into hold; latch remaining = hold[ws-1:0]; go to TX_SH.
  - TX_SH: out_valid=1, out_tag=00, out_data = hold high half. On handshake, go to TX_SL.
  - TX_SL: out_valid=1, tag 01, out_data = low half, out_last = (remaining==0). On handshake: if remaining==0, increment frames_done and go to IDLE; else go to WAIT_R.
  - WAIT_R: if result_population>0, go to RD_R. Stall indefinitely while the result FIFO is empty; out_valid=0 while stalled.
  - RD_R: result_rd_en=1 for one cycle; go to CAP_R.
  - CAP_R: latch result_data into hold; remaining -= 1; go to TX_RH.
  - TX_RH: tag 10, high half; on handshake go to TX_RL.
  - TX_RL: tag 11, low half, out_last = (remaining==0). On handshake: if remaining==0, frames_done++ and go to IDLE; else go to WAIT_R.
- Rd_en strobes and out_* are decoded from registered state and hold only; no combinational path from out_ready to any output.
- Pops never occur while a half-word is pending. At most one FIFO entry is in flight, so no FIFO overrun or underrun is possible.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_tag/out_last are held stable.
- Latency: status_population going nonzero in IDLE gives out_valid 3 cycles later. Back-to-back result words under continuous out_ready take 5 cycles per word.
- N=0: the frame is exactly two half-words, and out_last is set on the status-low half-word.
- Result count is word_size wide and taken unmodified (0..2^ws-1). remaining never underflows because decrement happens only when remaining>0.
- Status and result populations are sampled only in IDLE and WAIT_R respectively.

Decomposition:
- Shared package pea_pkg:
  - mode encodings GET_COMMAND/STP/EVP/EVB/OUTPUT/RST
  - out_tag encodings
  - status-word field offsets (STAT_ERR_BIT, STAT_MODE_LSB, STAT_CNT_MSB)
  - the log2 function
- Reader state encodings stay local to the module.
- No sub-module: one FSM plus hold register, remaining counter and frames_done counter.

Test Plan:
- Reset: rst=0 mid-TX_RH with out_valid=1 -> out_valid=0 immediately, frames_done=0; after release, IDLE with no rd_en until status_population>0.
- Zero-count frame: status 0x0001_0000 (STP, N=0), out_ready=1 -> out_data 0x0001 tag00, then 0x0000 tag01 with out_last=1; result_rd_en never asserts; frames_done=1.
- Two-result frame: status 0x0002_0002 (EVP, N=2), results 0x1234_5678 and 0x9ABC_DEF0 -> half-words 0x0002, 0x0002, 0x1234, 0x5678, 0x9ABC, 0xDEF0 with tags 00,01,10,11,10,11; out_last only on 0xDEF0; exactly one status pop and two result pops.
- Backpressure: hold out_ready=0 for 7 cycles during TX_RH -> out_data stays 0x1234 and out_valid stays 1 throughout; no extra rd_en pulses.
- Result starvation: status N=3 with only 1 result queued -> reader parks in WAIT_R with out_valid=0; push 2 more results 20 cycles later -> remaining half-words are emitted and the frame completes.
- Back-to-back frames: 3 status entries queued (N=1,0,1) -> frames_done reaches 3; each status is popped exactly once and in order.
